wake_setup_ctrl: RTL
====================

// Module: wake_setup_ctrl
// PURPOSE
//  User-interface sequencer for the alarm-clock core. Turns three debounced buttons into
//  time/alarm edit sessions and drives the core's load ports (H_in1/H_in0/M_in1/M_in0,
//  LD_time, LD_alarm, STOP_al). Holds each load strobe long enough for the core's 1 Hz
//  sampling domain. Sits between the front-panel button debouncers and the clock core.
// PARAMETERS
//  LD_HOLD     10   clk cycles each load/stop strobe is held high (>= 1 s at 10 Hz)
//  TIMEOUT     300  clk cycles without a button press before an edit is abandoned (30 s)
//  SNOOZE_MIN  5    minutes added to the current time on snooze (1..59)
// PORTS
//  clk          in   1  10 Hz system clock; all logic on rising edge
//  reset        in   1  synchronous, active-high
//  btn_mode     in   1  debounced, clk-synchronous level
//  btn_inc      in   1  debounced, clk-synchronous level
//  btn_snooze   in   1  debounced, clk-synchronous level
//  alarm_in     in   1  Alarm output of the clock core
//  cur_h1/cur_h0/cur_m1/cur_m0  in 2/4/4/4  current BCD time from the core
//  H_in1/H_in0/M_in1/M_in0      out 2/4/4/4 BCD value presented to the core (registered)
//  LD_time      out  1  time-load strobe to the core
//  LD_alarm     out  1  alarm-load strobe to the core
//  STOP_al      out  1  alarm-stop strobe to the core
//  editing      out  1  high in any EDIT_* state
//  edit_field   out  2  0 = none, 1 = hours, 2 = minutes (display blink select)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, alarm shadow = 00:00, timeout counter 0. Reset
//    mid-edit or mid-strobe aborts immediately; no partial load is completed.
//  - Press = rising edge of a button (registered previous level). State acts on the edge
//    after detection. Presses in COMMIT/STOP/SNZ_LOAD are ignored.
//  - Edit registers: hr (5 b, 0..23), mn (6 b, 0..59) in binary. BCD conversion to the
//    H_in*/M_in* outputs is registered, so outputs follow the edit registers 1 cycle later.
//  - States and transitions:
//    IDLE:      mode press -> EDIT_TH, hr/mn loaded from cur_*. inc press -> EDIT_AH,
//               hr/mn loaded from alarm shadow. snooze press with alarm_in=1 -> STOP.
//    EDIT_TH/AH: inc -> hr = (hr==23) ? 0 : hr+1. mode -> EDIT_TM/AM.
//    EDIT_TM/AM: inc -> mn = (mn==59) ? 0 : mn+1. mode -> COMMIT (T or A flavour).
//    COMMIT:    LD_time (T) or LD_alarm (A) high for exactly LD_HOLD cycles, with H_in*/M_in*
//               stable; A flavour writes hr/mn into the alarm shadow. Then -> IDLE.
//    STOP:      STOP_al high for LD_HOLD cycles, then -> SNZ_LOAD (macro on) or IDLE.
//    SNZ_LOAD:  see CONFIGURATION.
//  - Simultaneous mode and inc presses in EDIT_*: mode wins, inc is dropped.
//  - Timeout: the counter clears on any press and increments in EDIT_*. At TIMEOUT,
//    -> IDLE with no strobe; H_in*/M_in* revert to their last committed values.
//  - Strobes are mutually exclusive; at most one of LD_time/LD_alarm/STOP_al is high.
//  - In IDLE, H_in*/M_in* hold the last committed value.
// CONFIGURATION
//  WAKE_SNOOZE_EN defined: after STOP, SNZ_LOAD computes cur time + SNOOZE_MIN with
//    minute/hour wrap (23:58 + 5 -> 00:03). It presents that value and asserts LD_alarm
//    for LD_HOLD cycles. The alarm shadow is NOT modified, so the next user edit starts
//    from the user alarm.
//  WAKE_SNOOZE_EN undefined: there is no SNZ_LOAD state. STOP -> IDLE, and the snooze
//    button only stops the alarm.
//  In both builds, snooze presses with alarm_in=0 are ignored.
// TESTING
//  1 reset; mode; inc x3; mode; inc x2; mode -> LD_time high 10 cycles, H_in=03 M_in=02
//    when cur=00:00.
//  2 inc (alarm edit from 00:00); inc x24 -> hr wraps to 00; mode; inc x60 -> mn 00;
//    mode -> LD_alarm 10 cycles, 00:00.
//  3 enter EDIT_TH; no presses for 300 cycles -> IDLE, editing=0, no strobe ever raised.
//  4 alarm_in=1, cur=23:58, snooze -> STOP_al 10 cycles; then, with the macro, LD_alarm
//    10 cycles with H_in=00 M_in=03. Without the macro, there is no LD_alarm.
//  5 mode and inc pressed in the same cycle in EDIT_TH -> moves to EDIT_TM, hr unchanged.
//  6 reset asserted at cycle 4 of a COMMIT -> LD_time=0 next edge, shadow = 00:00.

Source files
------------

// File: rtl/wake_setup_ctrl_if.sv
// Button and clock-core signal bundle for wake_setup_ctrl.
// The master modport is the sequencer. The slave modport is the panel/core side.
interface wake_setup_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_snooze;
    logic       alarm_in;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [3:0] cur_m1;
    logic [3:0] cur_m0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       editing;
    logic [1:0] edit_field;

    modport master (
        input  btn_mode, btn_inc, btn_snooze, alarm_in,
        input  cur_h1, cur_h0, cur_m1, cur_m0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, STOP_al, editing, edit_field
    );

    modport slave (
        output btn_mode, btn_inc, btn_snooze, alarm_in,
        output cur_h1, cur_h0, cur_m1, cur_m0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, STOP_al, editing, edit_field
    );
endinterface

// File: rtl/wake_setup_ctrl.sv
// Button-driven time/alarm edit sequencer that feeds the alarm-clock core's load ports.
// Define WAKE_SNOOZE_EN to reload the alarm with current time + SNOOZE_MIN after a stop.
module wake_setup_ctrl #(
    parameter int LD_HOLD    = 10,
    parameter int TIMEOUT    = 300,
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              reset,
    wake_setup_ctrl_if.master bus
);
    localparam int HOLD_W = $clog2(LD_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LD_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EDIT_TH,
        ST_EDIT_TM,
        ST_EDIT_AH,
        ST_EDIT_AM,
        ST_COMMIT_T,
        ST_COMMIT_A,
`ifdef WAKE_SNOOZE_EN
        ST_SNZ_LOAD,
`endif
        ST_STOP
    } state_t;

    state_t r_state, w_next;

    logic              r_prev_mode, r_prev_inc, r_prev_snz;
    logic [4:0]        r_hr, r_sh_h, r_com_h;
    logic [5:0]        r_mn, r_sh_m, r_com_m;
    logic [TMO_W-1:0]  r_tmo;
    logic [HOLD_W-1:0] r_hold;
    logic [5:0]        r_bcd_h;
    logic [7:0]        r_bcd_m;

    logic       w_mode_p, w_inc_p, w_snz_p, w_any_p;
    logic       w_edit_h, w_edit_m, w_editing, w_committing, w_in_strobe;
    logic       w_hold_done, w_tmo_done;
    logic [4:0] w_cur_hb, w_hr_inc, w_out_h;
    logic [5:0] w_cur_mb, w_mn_inc, w_out_m;
    logic       w_out_load;

    function automatic logic [5:0] f_bcd_h(input logic [4:0] h);
        logic [4:0] rem;
        logic [1:0] tens;
        rem  = h;
        tens = 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (rem >= 5'd10) begin
                rem  = rem - 5'd10;
                tens = tens + 2'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [7:0] f_bcd_m(input logic [5:0] m);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = m;
        tens = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign w_mode_p = bus.btn_mode & ~r_prev_mode;
    assign w_inc_p  = bus.btn_inc & ~r_prev_inc;
    assign w_snz_p  = bus.btn_snooze & ~r_prev_snz;
    assign w_any_p  = w_mode_p | w_inc_p | w_snz_p;

    assign w_edit_h     = (r_state == ST_EDIT_TH) || (r_state == ST_EDIT_AH);
    assign w_edit_m     = (r_state == ST_EDIT_TM) || (r_state == ST_EDIT_AM);
    assign w_editing    = w_edit_h || w_edit_m;
    assign w_committing = (r_state == ST_COMMIT_T) || (r_state == ST_COMMIT_A);
    assign w_in_strobe  = bus.LD_time | bus.LD_alarm | bus.STOP_al;
    assign w_hold_done  = (r_hold == HOLD_LAST);
    assign w_tmo_done   = (r_tmo == TMO_LAST) && !w_any_p;

    assign w_cur_hb = 5'd10 * {3'b000, bus.cur_h1} + {1'b0, bus.cur_h0};
    assign w_cur_mb = 6'd10 * {2'b00, bus.cur_m1} + {2'b00, bus.cur_m0};
    assign w_hr_inc = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
    assign w_mn_inc = (r_mn == 6'd59) ? 6'd0 : r_mn + 6'd1;

`ifdef WAKE_SNOOZE_EN
    logic [6:0] w_snz_sum;
    logic       w_snz_wrap;
    logic [4:0] w_snz_h;
    logic [5:0] w_snz_m;
    assign w_snz_sum  = {1'b0, w_cur_mb} + 7'(SNOOZE_MIN);
    assign w_snz_wrap = (w_snz_sum >= 7'd60);
    assign w_snz_m    = w_snz_wrap ? 6'(w_snz_sum - 7'd60) : w_snz_sum[5:0];
    assign w_snz_h    = !w_snz_wrap ? w_cur_hb : (w_cur_hb == 5'd23) ? 5'd0 : w_cur_hb + 5'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Mode outranks inc so a simultaneous press only advances the field.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mode_p)                     w_next = ST_EDIT_TH;
                else if (w_inc_p)                 w_next = ST_EDIT_AH;
                else if (w_snz_p && bus.alarm_in) w_next = ST_STOP;
            end
            ST_EDIT_TH:  if (w_mode_p) w_next = ST_EDIT_TM;  else if (w_tmo_done) w_next = ST_IDLE;
            ST_EDIT_TM:  if (w_mode_p) w_next = ST_COMMIT_T; else if (w_tmo_done) w_next = ST_IDLE;
            ST_EDIT_AH:  if (w_mode_p) w_next = ST_EDIT_AM;  else if (w_tmo_done) w_next = ST_IDLE;
            ST_EDIT_AM:  if (w_mode_p) w_next = ST_COMMIT_A; else if (w_tmo_done) w_next = ST_IDLE;
            ST_COMMIT_T: if (w_hold_done) w_next = ST_IDLE;
            ST_COMMIT_A: if (w_hold_done) w_next = ST_IDLE;
`ifdef WAKE_SNOOZE_EN
            ST_STOP:     if (w_hold_done) w_next = ST_SNZ_LOAD;
            ST_SNZ_LOAD: if (w_hold_done) w_next = ST_IDLE;
`else
            ST_STOP:     if (w_hold_done) w_next = ST_IDLE;
`endif
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.editing    = w_editing;
        bus.edit_field = w_edit_h ? 2'd1 : (w_edit_m ? 2'd2 : 2'd0);
        bus.LD_time    = (r_state == ST_COMMIT_T);
        bus.LD_alarm   = (r_state == ST_COMMIT_A);
        bus.STOP_al    = (r_state == ST_STOP);
`ifdef WAKE_SNOOZE_EN
        if (r_state == ST_SNZ_LOAD) bus.LD_alarm = 1'b1;
`endif
    end

    // Commits latch the edit registers on the mode press that enters COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_mode <= 1'b0;
            r_prev_inc  <= 1'b0;
            r_prev_snz  <= 1'b0;
            r_hr        <= '0;
            r_mn        <= '0;
            r_sh_h      <= '0;
            r_sh_m      <= '0;
            r_com_h     <= '0;
            r_com_m     <= '0;
            r_tmo       <= '0;
            r_hold      <= '0;
        end else begin
            r_prev_mode <= bus.btn_mode;
            r_prev_inc  <= bus.btn_inc;
            r_prev_snz  <= bus.btn_snooze;
            r_tmo       <= (!w_editing || w_any_p) ? '0 : r_tmo + 1'b1;
            r_hold      <= (!w_in_strobe || (w_next != r_state)) ? '0 : r_hold + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_mode_p) begin
                        r_hr <= w_cur_hb;
                        r_mn <= w_cur_mb;
                    end else if (w_inc_p) begin
                        r_hr <= r_sh_h;
                        r_mn <= r_sh_m;
                    end
                end
                ST_EDIT_TH, ST_EDIT_AH: if (w_inc_p && !w_mode_p) r_hr <= w_hr_inc;
                ST_EDIT_TM: begin
                    if (w_inc_p && !w_mode_p) r_mn <= w_mn_inc;
                    if (w_mode_p) begin
                        r_com_h <= r_hr;
                        r_com_m <= r_mn;
                    end
                end
                ST_EDIT_AM: begin
                    if (w_inc_p && !w_mode_p) r_mn <= w_mn_inc;
                    if (w_mode_p) begin
                        r_com_h <= r_hr;
                        r_com_m <= r_mn;
                        r_sh_h  <= r_hr;
                        r_sh_m  <= r_mn;
                    end
                end
                default: ;
            endcase
        end
    end

    // Snooze value goes straight to the outputs so it is valid on the first LD_alarm cycle.
    always_comb begin
        w_out_load = 1'b1;
        w_out_h    = r_com_h;
        w_out_m    = r_com_m;
        if (w_editing || w_committing) begin
            w_out_h = r_hr;
            w_out_m = r_mn;
        end
`ifdef WAKE_SNOOZE_EN
        if ((r_state == ST_STOP) && (w_next == ST_SNZ_LOAD)) begin
            w_out_h = w_snz_h;
            w_out_m = w_snz_m;
        end
        if (r_state == ST_SNZ_LOAD) w_out_load = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd_h <= '0;
            r_bcd_m <= '0;
        end else if (w_out_load) begin
            r_bcd_h <= f_bcd_h(w_out_h);
            r_bcd_m <= f_bcd_m(w_out_m);
        end
    end

    assign bus.H_in1 = r_bcd_h[5:4];
    assign bus.H_in0 = r_bcd_h[3:0];
    assign bus.M_in1 = r_bcd_m[7:4];
    assign bus.M_in0 = r_bcd_m[3:0];
endmodule
